// File: rtl/conv_pkg.sv
// Shared types and constants for the 7x7 RGB convolution sequencer.
// Optional build macro: CONV_SATURATE_EN (clamp outputs, adds sat_flag).
package conv_pkg;

    localparam int TAPS  = 49;
    localparam int PIX_W = 8;
    localparam int ACC_W = 22;
    localparam int TAP_W = 6;

    localparam logic [TAP_W-1:0] TAP_END      = TAP_W'(TAPS);
    localparam logic [TAP_W-1:0] CFG_DIV_ADDR = 6'd49;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        NORM,
        DONE
    } conv_state_t;

    function automatic logic [PIX_W-1:0] eff_div(input logic [PIX_W-1:0] d);
        return (d == '0) ? PIX_W'(1) : d;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One colour channel: registered 8x8 product feeding an ACC_W accumulator.
// Optional build macro: none (see conv_sequencer for CONV_SATURATE_EN).
module conv_mac_lane
    import conv_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [TAPS*PIX_W-1:0]   win_i,
    input  logic [TAP_W-1:0]        tap_i,
    input  logic [PIX_W-1:0]        coef_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    output logic [ACC_W-1:0]        acc_o
);

    logic [2*PIX_W-1:0] prod_d, prod_q;
    logic [ACC_W-1:0]   acc_d, acc_q;
    logic [PIX_W-1:0]   pix;

    always_comb begin
        pix    = en_i ? win_i[tap_i*PIX_W +: PIX_W] : '0;
        prod_d = en_i ? (16'(coef_i) * 16'(pix)) : '0;
        acc_d  = acc_q + ACC_W'(prod_q);
    end

    // The product stage drains into the accumulator one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (clear_i) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_sequencer.sv
// Time-multiplexed 7x7 RGB convolution: FSM, tap counter, config regs, divider.
// Optional build macro: CONV_SATURATE_EN (clamp to 255 and drive sat_flag).
module conv_sequencer
    import conv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
`ifdef CONV_SATURATE_EN
    output logic                  sat_flag,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TAPS*PIX_W-1:0] red_in,
    input  logic [TAPS*PIX_W-1:0] green_in,
    input  logic [TAPS*PIX_W-1:0] blue_in,
    input  logic                  cfg_we,
    input  logic [TAP_W-1:0]      cfg_addr,
    input  logic [PIX_W-1:0]      cfg_data,
    output logic                  cfg_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_W-1:0]      red_out,
    output logic [PIX_W-1:0]      green_out,
    output logic [PIX_W-1:0]      blue_out
);

    conv_state_t state_q, state_d;

    logic [TAP_W-1:0]      tap_q, tap_d;
    logic [PIX_W-1:0]      kernel_q [TAPS];
    logic [PIX_W-1:0]      div_q;
    logic [TAPS*PIX_W-1:0] win_r_q, win_g_q, win_b_q;
    logic [PIX_W-1:0]      red_q, green_q, blue_q;
    logic                  cfg_err_q;

    logic             accept, mac_en, cfg_hit;
    logic [PIX_W-1:0] coef;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b;
    logic [ACC_W-1:0] den, q_r, q_g, q_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)         state_d = MAC;
            MAC:  if (tap_q == TAP_END) state_d = NORM;
            NORM:                       state_d = DONE;
            DONE: if (out_ready)        state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        accept    = in_ready && in_valid;
        mac_en    = (state_q == MAC) && (tap_q < TAP_END);
        cfg_hit   = cfg_we && (state_q == IDLE);
    end

    // Tap counter parks at TAP_END for the cycle the last product drains
    always_comb begin
        tap_d = tap_q;
        if (accept)                         tap_d = '0;
        else if (mac_en)                    tap_d = tap_q + 6'd1;
        coef = mac_en ? kernel_q[tap_q] : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tap_q   <= '0;
            win_r_q <= '0;
            win_g_q <= '0;
            win_b_q <= '0;
        end else begin
            tap_q <= tap_d;
            if (accept) begin
                win_r_q <= red_in;
                win_g_q <= green_in;
                win_b_q <= blue_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) kernel_q[i] <= '0;
            div_q     <= PIX_W'(1);
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && (state_q != IDLE);
            if (cfg_hit && (cfg_addr < TAP_END))
                kernel_q[cfg_addr] <= cfg_data;
            if (cfg_hit && (cfg_addr == CFG_DIV_ADDR))
                div_q <= cfg_data;
        end
    end

    assign cfg_err = cfg_err_q;

    conv_mac_lane u_lane_r (
        .clock(clock), .reset_n(reset_n), .win_i(win_r_q), .tap_i(tap_q),
        .coef_i(coef), .clear_i(accept), .en_i(mac_en), .acc_o(acc_r)
    );

    conv_mac_lane u_lane_g (
        .clock(clock), .reset_n(reset_n), .win_i(win_g_q), .tap_i(tap_q),
        .coef_i(coef), .clear_i(accept), .en_i(mac_en), .acc_o(acc_g)
    );

    conv_mac_lane u_lane_b (
        .clock(clock), .reset_n(reset_n), .win_i(win_b_q), .tap_i(tap_q),
        .coef_i(coef), .clear_i(accept), .en_i(mac_en), .acc_o(acc_b)
    );

    always_comb begin
        den = ACC_W'(eff_div(div_q));
        q_r = acc_r / den;
        q_g = acc_g / den;
        q_b = acc_b / den;
    end

    function automatic logic [PIX_W-1:0] fit(input logic [ACC_W-1:0] q);
`ifdef CONV_SATURATE_EN
        return (q > ACC_W'(255)) ? 8'hFF : q[PIX_W-1:0];
`else
        return q[PIX_W-1:0];
`endif
    endfunction

`ifdef CONV_SATURATE_EN
    logic sat_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            sat_q <= 1'b0;
        else if (state_q == NORM)
            sat_q <= (q_r > ACC_W'(255)) || (q_g > ACC_W'(255)) ||
                     (q_b > ACC_W'(255));
    end

    assign sat_flag = sat_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (state_q == NORM) begin
            red_q   <= fit(q_r);
            green_q <= fit(q_g);
            blue_q  <= fit(q_b);
        end
    end

    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer with a tap-sum reference model.
// Honours CONV_SATURATE_EN for the sat_flag port and clamp rule.
module tb_conv_sequencer;
    import conv_pkg::*;

    localparam int WW = TAPS * 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] red_in = '0, green_in = '0, blue_in = '0;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_addr = '0;
    logic [7:0]    cfg_data = '0;
    logic          cfg_err;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    red_out, green_out, blue_out;
    logic          sat_flag_w;

    conv_sequencer dut (
        .clock(clock),
        .reset_n(reset_n),
`ifdef CONV_SATURATE_EN
        .sat_flag(sat_flag_w),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .red_in(red_in),
        .green_in(green_in),
        .blue_in(blue_in),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_err(cfg_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .red_out(red_out),
        .green_out(green_out),
        .blue_out(blue_out)
    );

`ifndef CONV_SATURATE_EN
    assign sat_flag_w = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] r, g, b;
        bit         sat;
        int         acc_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int unsigned kern[TAPS];
    int unsigned divm = 1;
    bit          rmode = 1'b0;
    bit          seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WW-1:0] r, g, b);
        exp_t        e;
        longint      s[3];
        longint      q;
        longint      d;
        logic [7:0]  o[3];
        bit          sat;
        s = '{0, 0, 0};
        for (int k = 0; k < TAPS; k++) begin
            s[0] += longint'(kern[k]) * longint'(r[k*8 +: 8]);
            s[1] += longint'(kern[k]) * longint'(g[k*8 +: 8]);
            s[2] += longint'(kern[k]) * longint'(b[k*8 +: 8]);
        end
        d = (divm == 0) ? 1 : longint'(divm);
        sat = 1'b0;
        for (int c = 0; c < 3; c++) begin
            q = s[c] / d;
`ifdef CONV_SATURATE_EN
            if (q > 255) sat = 1'b1;
            o[c] = (q > 255) ? 8'hFF : 8'(q);
`else
            o[c] = 8'(q % 256);
`endif
        end
        e.r = o[0];
        e.g = o[1];
        e.b = o[2];
        e.sat = sat;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic void model_cfg(input logic [5:0] a, input logic [7:0] d);
        if (a < 6'd49) kern[a] = d;
        else if (a == 6'd49) divm = d;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sbq[0];
                if (!seen) begin
                    check("latency", cyc - e.acc_cyc, 51);
                    seen = 1'b1;
                end
                check("red_out", red_out, e.r);
                check("green_out", green_out, e.g);
                check("blue_out", blue_out, e.b);
                check("in_ready_busy", in_ready, 0);
`ifdef CONV_SATURATE_EN
                check("sat_flag", sat_flag_w, e.sat);
`endif
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (rmode) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_wait", 0, 1);
    endtask

    task automatic send(input logic [WW-1:0] r, g, b, input bit wcfg,
                        input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        wait_idle();
        red_in = r;
        green_in = g;
        blue_in = b;
        in_valid = 1'b1;
        if (wcfg) begin
            cfg_we = 1'b1;
            cfg_addr = a;
            cfg_data = d;
            model_cfg(a, d);
        end
        e = model(r, g, b);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        e.acc_cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic cfg_idle(input logic [5:0] a, input logic [7:0] d);
        wait_idle();
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        model_cfg(a, d);
        @(negedge clock);
        check("cfg_err_idle", cfg_err, 0);
    endtask

    task automatic cfg_busy(input logic [5:0] a, input logic [7:0] d);
        @(negedge clock);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        @(negedge clock);
        check("cfg_err_pulse", cfg_err, 1);
        @(negedge clock);
        check("cfg_err_clear", cfg_err, 0);
    endtask

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] w;
        for (int k = 0; k < TAPS; k++) w[k*8 +: 8] = 8'($urandom);
        return w;
    endfunction

    function automatic logic [WW-1:0] fill_win(input logic [7:0] v);
        logic [WW-1:0] w;
        for (int k = 0; k < TAPS; k++) w[k*8 +: 8] = v;
        return w;
    endfunction

    initial begin
        logic [WW-1:0] wr, wg, wb;
        bit            ok;

        for (int k = 0; k < TAPS; k++) kern[k] = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_red", red_out, 0);
        check("rst_green", green_out, 0);
        check("rst_blue", blue_out, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_sat", sat_flag_w, 0);

        // Identity kernel
        cfg_idle(6'd24, 8'd1);
        cfg_idle(6'd49, 8'd1);
        wr = rand_win(); wr[24*8 +: 8] = 8'd200;
        wg = rand_win(); wg[24*8 +: 8] = 8'd17;
        wb = rand_win(); wb[24*8 +: 8] = 8'd0;
        send(wr, wg, wb, 1'b0, '0, '0);

        // Box blur
        for (int k = 0; k < TAPS; k++) cfg_idle(6'(k), 8'd1);
        cfg_idle(6'd49, 8'd49);
        send(fill_win(8'd10), fill_win(8'd10), fill_win(8'd10), 1'b0, '0, '0);

        // Overflow
        for (int k = 0; k < TAPS; k++) cfg_idle(6'(k), 8'd255);
        cfg_idle(6'd49, 8'd1);
        send(fill_win(8'd255), fill_win(8'd255), fill_win(8'd255), 1'b0, '0, '0);

        // Backpressure for 10 cycles after out_valid
        wait_idle();
        out_ready = 1'b0;
        send(rand_win(), rand_win(), rand_win(), 1'b0, '0, '0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bp_valid_wait", 0, 1);
        repeat (10) @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_out_valid_clr", out_valid, 0);

        // Config guard while busy
        send(rand_win(), rand_win(), rand_win(), 1'b0, '0, '0);
        repeat (5) @(posedge clock);
        cfg_busy(6'd49, 8'd2);
        cfg_busy(6'd49, 8'd0);
        cfg_busy(6'd3, 8'd7);
        cfg_idle(6'd49, 8'd0);
        send(rand_win(), rand_win(), rand_win(), 1'b0, '0, '0);

        // Reset mid-MAC discards the window and clears config
        send(rand_win(), rand_win(), rand_win(), 1'b0, '0, '0);
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        void'(sbq.pop_front());
        seen = 1'b0;
        for (int k = 0; k < TAPS; k++) kern[k] = 0;
        divm = 1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_red", red_out, 0);
        check("mid_rst_cfg_err", cfg_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_in_ready", in_ready, 1);
        send(rand_win(), rand_win(), rand_win(), 1'b0, '0, '0);

        // Randomised traffic with random backpressure
        rmode = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int j = 0; j < 6; j++)
                cfg_idle(6'($urandom_range(0, 63)), 8'($urandom));
            cfg_idle(6'd49, 8'($urandom_range(0, 40)));
            send(rand_win(), rand_win(), rand_win(), 1'($urandom),
                 6'($urandom_range(0, 49)), 8'($urandom));
        end

        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
